// File: rtl/prbs_pkg.sv
// Shared types and default constants for the PRBS receive checker.
package prbs_pkg;

   typedef enum logic [1:0] {
      ST_HUNT   = 2'd0,
      ST_VERIFY = 2'd1,
      ST_LOCKED = 2'd2
   } state_e;

   localparam int unsigned PRBS3_WIDTH = 3;
   localparam logic [2:0]  PRBS3_TAPS  = 3'b101;

endpackage

// File: rtl/prbs_shadow_lfsr.sv
// Shadow copy of the transmit LFSR: shifts in received bits, or its own
// prediction when flywheeling, and exposes the predicted next bit.
module prbs_shadow_lfsr
   import prbs_pkg::*;
#(
   parameter int unsigned      WIDTH    = PRBS3_WIDTH,
   parameter logic [WIDTH-1:0] TAP_MASK = WIDTH'(PRBS3_TAPS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             shift_en,
   input  logic             flywheel,
   input  logic             in_bit,
   output logic [WIDTH-1:0] shadow,
   output logic             predicted
);

   logic [WIDTH-1:0] shadow_q, shadow_d;
   logic             nb;

   always_comb begin
      predicted = ^(shadow_q & TAP_MASK);
      nb        = flywheel ? predicted : in_bit;
      shadow_d  = shadow_q;
      if (shift_en) begin
         shadow_d = {shadow_q[WIDTH-2:0], nb};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shadow_q <= '0;
      end else begin
         shadow_q <= shadow_d;
      end
   end

   assign shadow = shadow_q;

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS checker: HUNT/VERIFY/LOCKED acquisition, flywheel
// tracking once locked, per-bit error pulse and saturating error counter.
module prbs_checker
   import prbs_pkg::*;
#(
   parameter int unsigned      WIDTH    = PRBS3_WIDTH,
   parameter logic [WIDTH-1:0] TAP_MASK = WIDTH'(PRBS3_TAPS),
   parameter int unsigned      LOCK_CNT = 8,
   parameter int unsigned      LOSS_CNT = 4,
   parameter int unsigned      CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             in_valid,
   input  logic             in_bit,
   output logic             locked,
   output logic             err_pulse,
   output logic [CNT_W-1:0] err_count,
   output logic             zero_flag
);

   localparam int unsigned FILL_W  = $clog2(WIDTH);
   localparam int unsigned MATCH_W = $clog2(LOCK_CNT + 1);
   localparam int unsigned MISS_W  = $clog2(LOSS_CNT + 1);

   state_e             state_q, state_d;
   logic [FILL_W-1:0]  fill_q, fill_d;
   logic [MATCH_W-1:0] match_q, match_d;
   logic [MISS_W-1:0]  miss_q, miss_d;
   logic [CNT_W-1:0]   err_count_q, err_count_d;
   logic               err_pulse_q, err_pulse_d;
   logic               locked_q, locked_d;
   logic               zero_flag_q, zero_flag_d;

   logic [WIDTH-1:0]   shadow;
   logic               predicted;
   logic               flywheel;
   logic               mismatch;
   logic               nb;
   logic               shadow_next_zero;

   assign flywheel = (state_q == ST_LOCKED);

   prbs_shadow_lfsr #(
      .WIDTH    (WIDTH),
      .TAP_MASK (TAP_MASK)
   ) u_shadow (
      .clk       (clk),
      .reset     (reset),
      .shift_en  (in_valid),
      .flywheel  (flywheel),
      .in_bit    (in_bit),
      .shadow    (shadow),
      .predicted (predicted)
   );

   always_comb begin
      state_d     = state_q;
      fill_d      = fill_q;
      match_d     = match_q;
      miss_d      = miss_q;
      err_count_d = err_count_q;
      err_pulse_d = 1'b0;
      mismatch    = (in_bit != predicted);
      nb          = flywheel ? predicted : in_bit;

      if (in_valid) begin
         case (state_q)
            ST_HUNT: begin
               if (fill_q == FILL_W'(WIDTH - 1)) begin
                  state_d = ST_VERIFY;
                  fill_d  = '0;
                  match_d = '0;
               end else begin
                  fill_d = fill_q + 1'b1;
               end
            end
            ST_VERIFY: begin
               if (mismatch) begin
                  state_d = ST_HUNT;
                  fill_d  = '0;
                  match_d = '0;
               end else if (match_q == MATCH_W'(LOCK_CNT - 1)) begin
                  state_d = ST_LOCKED;
                  match_d = '0;
                  miss_d  = '0;
               end else begin
                  match_d = match_q + 1'b1;
               end
            end
            ST_LOCKED: begin
               if (mismatch) begin
                  err_pulse_d = 1'b1;
                  if (err_count_q != '1) begin
                     err_count_d = err_count_q + 1'b1;
                  end
                  if (miss_q == MISS_W'(LOSS_CNT - 1)) begin
                     state_d = ST_HUNT;
                     fill_d  = '0;
                     miss_d  = '0;
                  end else begin
                     miss_d = miss_q + 1'b1;
                  end
               end else begin
                  miss_d = '0;
               end
            end
            default: state_d = ST_HUNT;
         endcase
      end

      // clear wins over any same-beat error increment or state move
      if (clear) begin
         state_d     = ST_HUNT;
         fill_d      = '0;
         match_d     = '0;
         miss_d      = '0;
         err_count_d = '0;
         err_pulse_d = 1'b0;
      end

      // zero_flag is registered, so look at the shadow value after this beat's shift
      shadow_next_zero = in_valid ? ({shadow[WIDTH-2:0], nb} == '0) : (shadow == '0);
      locked_d         = (state_d == ST_LOCKED);
      zero_flag_d      = locked_d && shadow_next_zero;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_HUNT;
         fill_q      <= '0;
         match_q     <= '0;
         miss_q      <= '0;
         err_count_q <= '0;
         err_pulse_q <= 1'b0;
         locked_q    <= 1'b0;
         zero_flag_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         fill_q      <= fill_d;
         match_q     <= match_d;
         miss_q      <= miss_d;
         err_count_q <= err_count_d;
         err_pulse_q <= err_pulse_d;
         locked_q    <= locked_d;
         zero_flag_q <= zero_flag_d;
      end
   end

   assign locked    = locked_q;
   assign err_pulse = err_pulse_q;
   assign err_count = err_count_q;
   assign zero_flag = zero_flag_q;

endmodule
